fc_argmax: RTL
==============

// Module: fc_argmax
// PURPOSE
//  Consumer end of the fully-connected layer's result interface. Detects the rising edge of fc_done,
//  snapshots the ten 32-bit class scores, and scans them one per cycle for the signed maximum.
//  Presents the winning class index and score on a valid/ready handshake to the downstream
//  result/display logic. Counts result frames lost because the block was busy.
// PARAMETERS
//  SCORE_WIDTH  32  width of each prob_k score; scores are interpreted as two's complement
//  NUM_CLASSES  10  number of scored classes; fixed at 10 to match ports prob_0..prob_9
//  IDX_WIDTH    4   width of class_idx; must satisfy 2**IDX_WIDTH >= NUM_CLASSES
//  DROP_WIDTH   8   width of the saturating drop_cnt counter
// PORTS
//  clk          in   1            system clock, all logic on posedge
//  rst          in   1            synchronous reset, active high
//  fc_done      in   1            level from FC stage; a new result is marked by its 0->1 transition
//  prob_0..9    in   SCORE_WIDTH  class scores, stable while fc_done is high
//  class_valid  out  1            class_idx and class_score hold a result
//  class_ready  in   1            downstream accepts the result when high together with class_valid
//  class_idx    out  IDX_WIDTH    index 0..9 of the maximum score
//  class_score  out  SCORE_WIDTH  the maximum score, signed
//  busy         out  1            high in SCAN or VALID
//  drop_cnt     out  DROP_WIDTH   saturating count of ignored fc_done rising edges
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-high.
//  - Reset values: class_valid=0, class_idx=0, class_score=0, busy=0, drop_cnt=0.
//    Internal state also resets: state=IDLE, fc_done_d=0, ptr=0, score regs=0.
//  - Edge detect: start = fc_done & ~fc_done_d, where fc_done_d is registered every cycle.
//    fc_done already high in the first cycle after reset counts as a start.
//  - FSM states: IDLE, SCAN, VALID.
//  - IDLE on start (edge E0):
//    * capture all 10 scores;
//    * best_score=prob_0, best_idx=0, ptr=1;
//    * go to SCAN.
//  - SCAN, one compare per edge:
//    * if $signed(score[ptr]) > $signed(best_score), update best_score and best_idx;
//    * the compare is strictly greater, so on a tie the lowest index wins;
//    * ptr increments each edge; the edge that processes ptr==9 (E9) moves to VALID.
//  - Output timing:
//    * class_valid is first high in the cycle after E9, 9 cycles after the capture edge;
//    * class_idx and class_score are loaded at E9.
//  - VALID:
//    * class_valid, class_idx and class_score stay stable until class_valid & class_ready at an edge;
//    * on that edge class_valid drops to 0 and the FSM returns to IDLE;
//    * class_idx and class_score keep their last values (don't-care while class_valid=0).
//  - Simultaneous events:
//    * a start on the same edge as the VALID accept is not dropped;
//    * it is captured as in IDLE and the FSM goes directly to SCAN, so class_valid is low next cycle.
//  - Drops:
//    * a start in SCAN, or in VALID without an accept, is ignored and increments drop_cnt;
//    * drop_cnt saturates at all-ones and clears only on rst;
//    * the in-progress scan and the held result are never disturbed by a dropped start.
//  - Scores in the snapshot are used for the whole scan, even if prob_k change while SCAN runs.
//  - busy = (state != IDLE).
//  - rst asserted mid-SCAN or in VALID aborts immediately: all outputs return to reset values next cycle.
//    A start is then required again before any new result appears.
//  - No arithmetic beyond the signed compare; scores are never truncated or extended.
// TESTING
//  1. prob_k=k*100 for k=0..9, pulse fc_done -> class_valid 9 cycles after capture edge; idx=9; score=900.
//  2. All scores negative, prob_3=-5 (max), others <=-100 -> idx=3, score=-5.
//     prob_0=32'h8000_0000 is never chosen over a positive score.
//  3. Ties: prob_2=prob_7=50, others 0 -> idx=2.
//     All ten equal to 7 -> idx=0, score=7.
//  4. class_ready low for 20 cycles after class_valid -> outputs stable throughout.
//     Two fc_done rising edges during that window -> drop_cnt=2, result unchanged.
//     Raise class_ready -> class_valid low next cycle.
//  5. Start coincident with accept edge -> no drop; new result valid 9 cycles later.
//     Drive 300 dropped starts -> drop_cnt saturates at 255.
//  6. Assert rst at scan cycle 4 -> next cycle class_valid=0, busy=0, drop_cnt=0.
//     fc_done held high across reset -> treated as a start after reset and scanned normally.

Source files
------------

// File: rtl/fc_argmax.sv
// Argmax consumer for the FC layer: snapshots ten signed scores on the rising edge of fc_done,
// scans them one per cycle and presents the winning index/score on a valid/ready handshake.
module fc_argmax #(
    parameter int SCORE_WIDTH = 32,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_WIDTH   = 4,
    parameter int DROP_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fc_done,
    input  logic [SCORE_WIDTH-1:0] prob_0,
    input  logic [SCORE_WIDTH-1:0] prob_1,
    input  logic [SCORE_WIDTH-1:0] prob_2,
    input  logic [SCORE_WIDTH-1:0] prob_3,
    input  logic [SCORE_WIDTH-1:0] prob_4,
    input  logic [SCORE_WIDTH-1:0] prob_5,
    input  logic [SCORE_WIDTH-1:0] prob_6,
    input  logic [SCORE_WIDTH-1:0] prob_7,
    input  logic [SCORE_WIDTH-1:0] prob_8,
    input  logic [SCORE_WIDTH-1:0] prob_9,
    output logic                   class_valid,
    input  logic                   class_ready,
    output logic [IDX_WIDTH-1:0]   class_idx,
    output logic [SCORE_WIDTH-1:0] class_score,
    output logic                   busy,
    output logic [DROP_WIDTH-1:0]  drop_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        VALID = 2'd2
    } state_t;

    localparam logic [IDX_WIDTH-1:0]   IDX_ZERO   = {IDX_WIDTH{1'b0}};
    localparam logic [IDX_WIDTH-1:0]   IDX_ONE    = {{(IDX_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [IDX_WIDTH-1:0]   LAST_PTR   = IDX_WIDTH'(NUM_CLASSES - 32'sd1);
    localparam logic [SCORE_WIDTH-1:0] SCORE_ZERO = {SCORE_WIDTH{1'b0}};
    localparam logic [DROP_WIDTH-1:0]  DROP_ZERO  = {DROP_WIDTH{1'b0}};
    localparam logic [DROP_WIDTH-1:0]  DROP_ONE   = {{(DROP_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DROP_WIDTH-1:0]  DROP_MAX   = {DROP_WIDTH{1'b1}};

    state_t                 state_r, state_s;
    logic                   fc_done_r;
    logic [IDX_WIDTH-1:0]   ptr_r, ptr_s;
    logic [SCORE_WIDTH-1:0] score_r [NUM_CLASSES];
    logic [SCORE_WIDTH-1:0] score_s [NUM_CLASSES];
    logic [SCORE_WIDTH-1:0] prob_s  [NUM_CLASSES];
    logic [SCORE_WIDTH-1:0] best_score_r, best_score_s;
    logic [IDX_WIDTH-1:0]   best_idx_r, best_idx_s;
    logic                   valid_s;
    logic [IDX_WIDTH-1:0]   idx_s;
    logic [SCORE_WIDTH-1:0] out_score_s;
    logic [DROP_WIDTH-1:0]  drop_s;
    logic                   start_s, accept_s, capture_s, drop_evt_s, greater_s;

    // Gather the flat score ports into an indexable array.
    always_comb begin
        prob_s[0] = prob_0;
        prob_s[1] = prob_1;
        prob_s[2] = prob_2;
        prob_s[3] = prob_3;
        prob_s[4] = prob_4;
        prob_s[5] = prob_5;
        prob_s[6] = prob_6;
        prob_s[7] = prob_7;
        prob_s[8] = prob_8;
        prob_s[9] = prob_9;
    end

    // Next-state and next-output logic for the scan FSM.
    always_comb begin
        start_s      = fc_done & ~fc_done_r;
        accept_s     = class_valid & class_ready;
        state_s      = state_r;
        ptr_s        = ptr_r;
        score_s      = score_r;
        best_score_s = best_score_r;
        best_idx_s   = best_idx_r;
        valid_s      = class_valid;
        idx_s        = class_idx;
        out_score_s  = class_score;
        drop_s       = drop_cnt;
        capture_s    = 1'b0;
        drop_evt_s   = 1'b0;
        // Strict compare keeps the lowest index on ties.
        greater_s    = $signed(score_r[ptr_r]) > $signed(best_score_r);

        case (state_r)
            IDLE: begin
                if (start_s) begin
                    capture_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                drop_evt_s = start_s;
                if (greater_s) begin
                    best_score_s = score_r[ptr_r];
                    best_idx_s   = ptr_r;
                end else begin
                    best_score_s = best_score_r;
                end
                if (ptr_r == LAST_PTR) begin
                    state_s     = VALID;
                    valid_s     = 1'b1;
                    idx_s       = best_idx_s;
                    out_score_s = best_score_s;
                end else begin
                    ptr_s = ptr_r + IDX_ONE;
                end
            end
            VALID: begin
                if (accept_s) begin
                    valid_s = 1'b0;
                    if (start_s) begin
                        capture_s = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    drop_evt_s = start_s;
                end
            end
            default: begin
                state_s = IDLE;
                valid_s = 1'b0;
            end
        endcase

        if (capture_s) begin
            score_s      = prob_s;
            best_score_s = prob_s[0];
            best_idx_s   = IDX_ZERO;
            ptr_s        = IDX_ONE;
            state_s      = SCAN;
        end else begin
            ptr_s = ptr_s;
        end

        if (drop_evt_s && (drop_cnt != DROP_MAX)) begin
            drop_s = drop_cnt + DROP_ONE;
        end else begin
            drop_s = drop_cnt;
        end
    end

    // State, snapshot and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            fc_done_r    <= 1'b0;
            ptr_r        <= IDX_ZERO;
            best_score_r <= SCORE_ZERO;
            best_idx_r   <= IDX_ZERO;
            class_valid  <= 1'b0;
            class_idx    <= IDX_ZERO;
            class_score  <= SCORE_ZERO;
            busy         <= 1'b0;
            drop_cnt     <= DROP_ZERO;
            for (int k = 0; k < NUM_CLASSES; k++) begin
                score_r[k] <= SCORE_ZERO;
            end
        end else begin
            state_r      <= state_s;
            fc_done_r    <= fc_done;
            ptr_r        <= ptr_s;
            best_score_r <= best_score_s;
            best_idx_r   <= best_idx_s;
            class_valid  <= valid_s;
            class_idx    <= idx_s;
            class_score  <= out_score_s;
            busy         <= (state_s != IDLE);
            drop_cnt     <= drop_s;
            for (int k = 0; k < NUM_CLASSES; k++) begin
                score_r[k] <= score_s[k];
            end
        end
    end

endmodule
